filter_out_decimator: RTL and testbench

//   Downstream stage of filter_original. Takes the filter's Width-bit two's-complement output stream.

---
 rtl/filter_out_decimator_if.sv | 24 ++
 rtl/filter_out_decimator.sv | 128 ++++++++++++
 tb/tb_filter_out_decimator.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/filter_out_decimator_if.sv
// Sample stream in, decimated valid/ready stream out, plus FIFO status.
// slave is the decimator's view, master is the producer/consumer side.
interface filter_out_decimator_if #(
    parameter int Width      = 10,
    parameter int FIFO_DEPTH = 4
);
    logic                          in_en;
    logic signed [Width-1:0]       data_in;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [Width-1:0]       data_out;
    logic [$clog2(FIFO_DEPTH):0]   fill;
    logic                          overflow;

    modport slave (
        input  in_en, data_in, out_ready,
        output out_valid, data_out, fill, overflow
    );

    modport master (
        output in_en, data_in, out_ready,
        input  out_valid, data_out, fill, overflow
    );
endinterface

// File: rtl/filter_out_decimator.sv
// Boxcar decimator: averages each block of 2**LOG2_DEC samples into a show-ahead FIFO.
// Optional macro DECIM_ROUND_EN: round half toward +inf instead of truncating.
module filter_out_decimator #(
    parameter int Width      = 10,
    parameter int LOG2_DEC   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input logic                   clk,
    input logic                   rst,
    filter_out_decimator_if.slave bus
);
    localparam int DEC = 1 << LOG2_DEC;
    localparam int AW  = Width + LOG2_DEC;
    localparam int PHW = (LOG2_DEC > 0) ? LOG2_DEC : 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam logic [PHW-1:0] LAST_PHASE = PHW'(DEC - 1);
    localparam logic [PW:0]    FULL_COUNT = (PW + 1)'(FIFO_DEPTH);

    logic signed [AW-1:0]    acc;
    logic signed [AW-1:0]    din_ext;
    logic signed [AW-1:0]    sum;
    logic [PHW-1:0]          phase;
    logic signed [Width-1:0] avg;

    logic signed [Width-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           rd_next;
    logic [PW:0]             count;
    logic signed [Width-1:0] data_q;
    logic signed [Width-1:0] next_data;
    logic                    overflow_q;

    logic last;
    logic push_req;
    logic full;
    logic pop;
    logic push_ok;

    assign din_ext = AW'(bus.data_in);
    assign sum     = acc + din_ext;

`ifdef DECIM_ROUND_EN
    // One extra bit so the rounding offset cannot wrap a full-scale positive sum.
    localparam logic signed [AW:0] RND = (AW + 1)'(DEC / 2);
    logic signed [AW:0] sum_rnd;
    assign sum_rnd = (AW + 1)'(sum) + RND;
    assign avg     = Width'(sum_rnd >>> LOG2_DEC);
`else
    assign avg = Width'(sum >>> LOG2_DEC);
`endif

    assign last     = (phase == LAST_PHASE);
    assign push_req = bus.in_en && last;
    assign full     = (count == FULL_COUNT);
    assign pop      = (count != '0) && bus.out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok  = push_req && (!full || pop);
    assign rd_next  = rd_ptr + PW'(1);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            phase <= '0;
        end else if (bus.in_en) begin
            if (last) begin
                acc   <= '0;
                phase <= '0;
            end else begin
                acc   <= sum;
                phase <= phase + PHW'(1);
            end
        end
    end

    // NOTE: storage has no reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= avg;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves next_data unassigned (no latch).
        next_data = data_q;
        if (pop) begin
            if (count > (PW + 1)'(1)) begin
                next_data = mem[rd_next];
            end else if (push_ok) begin
                next_data = avg;
            end
        end else if ((count == '0) && push_ok) begin
            next_data = avg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            data_q <= next_data;
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            if (push_ok && !pop) begin
                count <= count + (PW + 1)'(1);
            end else if (pop && !push_ok) begin
                count <= count - (PW + 1)'(1);
            end
            if (push_req && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.out_valid = (count != '0);
    assign bus.data_out  = data_q;
    assign bus.fill      = count;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_filter_out_decimator.sv
// Directed bench for filter_out_decimator at Width=10, LOG2_DEC=2, FIFO_DEPTH=4.
// Expectations follow DECIM_ROUND_EN when the macro is defined for the build.
module tb_filter_out_decimator;
    localparam int W = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    filter_out_decimator_if #(.Width(W), .FIFO_DEPTH(4)) bus ();

    filter_out_decimator #(.Width(W), .LOG2_DEC(2), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic signed [W-1:0] v);
        bus.in_en   = 1'b1;
        bus.data_in = v;
        step();
        bus.in_en   = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_en     = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.data_out !== 10'sd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", bus.data_out); end
        checks++; if (bus.fill !== 3'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", bus.fill); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
        step();
        rst = 1'b0;
        feed(10'sd4);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL first_early_valid got=%b exp=0", bus.out_valid); end
        feed(10'sd8);
        feed(10'sd12);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL first_early_valid3 got=%b exp=0", bus.out_valid); end
        feed(10'sd16);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.data_out !== 10'sd10) begin failures++; $display("FAIL first_data got=%0d exp=10", bus.data_out); end
        checks++; if (bus.fill !== 3'd1) begin failures++; $display("FAIL first_fill got=%0d exp=1", bus.fill); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL first_one_cycle got=%b exp=0", bus.out_valid); end
        checks++; if (bus.data_out !== 10'sd10) begin failures++; $display("FAIL empty_hold got=%0d exp=10", bus.data_out); end
    endtask

    task automatic test_rounding();
        logic signed [W-1:0] exp_avg;
`ifdef DECIM_ROUND_EN
        exp_avg = -10'sd1;
`else
        exp_avg = -10'sd2;
`endif
        feed(-10'sd1);
        feed(-10'sd1);
        feed(-10'sd1);
        feed(-10'sd2);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL neg_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.data_out !== exp_avg) begin failures++; $display("FAIL neg_avg got=%0d exp=%0d", bus.data_out, exp_avg); end
        step();
    endtask

    task automatic test_extremes();
        for (int i = 0; i < 4; i++) feed(10'sd511);
        checks++; if (bus.data_out !== 10'sd511) begin failures++; $display("FAIL max_avg got=%0d exp=511", bus.data_out); end
        step();
        for (int i = 0; i < 4; i++) feed(-10'sd512);
        checks++; if (bus.data_out !== -10'sd512) begin failures++; $display("FAIL min_avg got=%0d exp=-512", bus.data_out); end
        step();
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL extremes_overflow got=%b exp=0", bus.overflow); end
    endtask

    task automatic test_backpressure();
        logic signed [W-1:0] exp_q [4];
`ifdef DECIM_ROUND_EN
        exp_q = '{10'sd3, 10'sd7, 10'sd11, 10'sd15};
`else
        exp_q = '{10'sd2, 10'sd6, 10'sd10, 10'sd14};
`endif
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            feed(W'(i));
            if (i == 4) begin
                checks++; if (bus.data_out !== exp_q[0]) begin failures++; $display("FAIL bp_first_head got=%0d exp=%0d", bus.data_out, exp_q[0]); end
            end
            if (i == 16) begin
                checks++; if (bus.fill !== 3'd4) begin failures++; $display("FAIL bp_full_fill got=%0d exp=4", bus.fill); end
                checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL bp_pre_overflow got=%b exp=0", bus.overflow); end
            end
        end
        checks++; if (bus.fill !== 3'd4) begin failures++; $display("FAIL bp_drop_fill got=%0d exp=4", bus.fill); end
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow got=%b exp=1", bus.overflow); end
        step();
        checks++; if (bus.data_out !== exp_q[0]) begin failures++; $display("FAIL bp_stable_head got=%0d exp=%0d", bus.data_out, exp_q[0]); end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus.data_out !== exp_q[k]) begin failures++; $display("FAIL bp_pop%0d got=%0d exp=%0d", k, bus.data_out, exp_q[k]); end
            checks++; if (bus.fill !== 3'(4 - k)) begin failures++; $display("FAIL bp_fill%0d got=%0d exp=%0d", k, bus.fill, 4 - k); end
            step();
        end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.fill !== 3'd0) begin failures++; $display("FAIL bp_drained_fill got=%0d exp=0", bus.fill); end
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL bp_sticky got=%b exp=1", bus.overflow); end
    endtask

    task automatic test_full_with_pop();
        pulse_reset();
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL fp_reset_overflow got=%b exp=0", bus.overflow); end
        bus.out_ready = 1'b0;
        for (int b = 1; b <= 4; b++)
            for (int j = 0; j < 4; j++) feed(W'(b));
        checks++; if (bus.fill !== 3'd4) begin failures++; $display("FAIL fp_fill got=%0d exp=4", bus.fill); end
        for (int j = 0; j < 3; j++) feed(10'sd5);
        bus.out_ready = 1'b1;
        feed(10'sd5);
        checks++; if (bus.fill !== 3'd4) begin failures++; $display("FAIL fp_fill_kept got=%0d exp=4", bus.fill); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL fp_no_drop got=%b exp=0", bus.overflow); end
        for (int k = 2; k <= 5; k++) begin
            checks++; if (bus.data_out !== W'(k)) begin failures++; $display("FAIL fp_order got=%0d exp=%0d", bus.data_out, k); end
            step();
        end
        checks++; if (bus.fill !== 3'd0) begin failures++; $display("FAIL fp_drained got=%0d exp=0", bus.fill); end
    endtask

    task automatic test_reset_mid_block();
        logic signed [W-1:0] samples [4];
        samples = '{10'sd4, 10'sd8, 10'sd12, 10'sd16};
        bus.out_ready = 1'b1;
        feed(10'sd100);
        feed(10'sd100);
        pulse_reset();
        checks++; if (bus.fill !== 3'd0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset got fill=%0d valid=%b exp fill=0 valid=0", bus.fill, bus.out_valid); end
        for (int i = 0; i < 4; i++) begin
            feed(samples[i]);
            if (i < 3) begin
                checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL gap_early%0d got=%b exp=0", i, bus.out_valid); end
                step();
                checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL gap_idle%0d got=%b exp=0", i, bus.out_valid); end
            end
        end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL gap_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.data_out !== 10'sd10) begin failures++; $display("FAIL gap_avg got=%0d exp=10", bus.data_out); end
        step();
        step();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL gap_single got=%b exp=0", bus.out_valid); end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_extremes();
        test_backpressure();
        test_full_with_pop();
        test_reset_mid_block();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
